// File: rtl/instruction_fetch.sv
// IF stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers returned words in a small prefetch FIFO and presents registered inst/pc to ID.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        branch_taken,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc;
    logic             issue_en;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [CNT_W-1:0] discard, discard_next;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_rd, fifo_wr, tag_rd, tag_wr;
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      tag_pc    [FIFO_DEPTH];
    logic             redirect, grant, drop, push, pop;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W:0]   held_words;
    logic [31:0]      redirect_pc;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // The entry popped to ID this cycle frees its slot, which is what allows
    // one instruction per cycle with a two-entry budget.
    always_comb begin
        redirect     = branch_taken & clk_en;
        grant        = imem_req & imem_gnt;
        drop         = imem_rvalid & ((discard != '0) | redirect);
        push         = imem_rvalid & ~drop;
        pop          = clk_en & ~redirect & (fifo_count != '0);
        occupancy    = {1'b0, outstanding} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
        imem_req     = issue_en & (state == RUN) & (occupancy < DEPTH_W);
        redirect_pc  = jump_addr & ~32'd3;

        outstanding_next = outstanding;
        if (grant & ~imem_rvalid) begin
            outstanding_next = outstanding + CNT_ONE;
        end else if (~grant & imem_rvalid) begin
            outstanding_next = outstanding - CNT_ONE;
        end

        discard_next = discard;
        if (redirect) begin
            discard_next = outstanding_next;
        end else if (imem_rvalid && discard != '0) begin
            discard_next = discard - CNT_ONE;
        end

        state_next = state;
        if (redirect) begin
            state_next = (discard_next != '0) ? DRAIN : RUN;
        end else if (state == DRAIN && discard_next == '0) begin
            state_next = RUN;
        end
    end

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            issue_en    <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            inst        <= NOP_INST;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
        end else begin
            issue_en    <= 1'b1;
            state       <= state_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;

            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // Tags track every request in flight, including wrong-path ones.
            if (grant) begin
                tag_pc[tag_wr] <= fetch_pc;
                tag_wr         <= next_ptr(tag_wr);
            end
            if (imem_rvalid) begin
                tag_rd <= next_ptr(tag_rd);
            end

            if (redirect) begin
                fifo_count <= '0;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
            end else begin
                if (push) begin
                    fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
                    fifo_inst[fifo_wr] <= imem_rdata;
                    fifo_wr            <= next_ptr(fifo_wr);
                end
                if (pop) begin
                    fifo_rd <= next_ptr(fifo_rd);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_ONE;
                    2'b01:   fifo_count <= fifo_count - CNT_ONE;
                    default: fifo_count <= fifo_count;
                endcase
            end

            if (clk_en) begin
                if (pop) begin
                    inst       <= fifo_inst[fifo_rd];
                    pc         <= fifo_pc[fifo_rd];
                    inst_valid <= 1'b1;
                end else begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                end
            end
        end
    end

    assign held_words = {1'b0, outstanding} + {1'b0, fifo_count};

    occupancy_cap: assert property (@(posedge clk) disable iff (rst) held_words <= DEPTH_W);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an in-order, fixed-latency memory model
// driven from the stimulus sequence.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        branch_taken;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int cyc    = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2),
        .NOP_INST  (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .branch_taken(branch_taken),
        .jump_addr   (jump_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a << 8) ^ 32'hC0FF_EE13;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic br, input logic [31:0] target);
        clk_en       = en;
        branch_taken = br;
        jump_addr    = target;
        #1;
    endtask

    // One clock: memory model bookkeeping plus a check on every word handed to ID.
    task automatic stepCycle();
        logic g, r, rv, en;
        logic [31:0] a;
        @(negedge clk);
        g  = imem_req & imem_gnt;
        a  = imem_addr;
        rv = imem_rvalid;
        r  = rst;
        en = clk_en;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (rv && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (g) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc - 1 + lat);
            end
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
        if (en) begin
            if (inst_valid) checkOutput("stream_inst", inst, memWord(pc));
            else            checkOutput("bubble_inst", inst, NOP);
        end
        #1;
    endtask

    task automatic waitReq(input int maxCycles);
        int n = 0;
        while (!imem_req && n < maxCycles) begin
            stepCycle();
            n++;
        end
        checkBit("req_wait", imem_req, 1'b1);
    endtask

    task automatic waitValid(input int maxCycles);
        int n = 0;
        while (!inst_valid && n < maxCycles) begin
            stepCycle();
            n++;
        end
        checkBit("valid_wait", inst_valid, 1'b1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_inst"}, inst, NOP);
        checkOutput({tag, "_pc"}, pc, 32'h0000_0000);
        checkBit({tag, "_valid"}, inst_valid, 1'b0);
        checkBit({tag, "_req"}, imem_req, 1'b0);
    endtask

    // Let every in-flight word return and drain to ID with grants held off.
    task automatic drainIdle(input int newLat);
        lat      = newLat;
        imem_gnt = 1'b0;
        repeat (8) stepCycle();
        checkBit("idle_valid", inst_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        clk_en       = 1'b1;
        branch_taken = 1'b0;
        jump_addr    = 32'd0;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'd0;

        $display("[TB] reset and zero-wait streaming");
        stepCycle();
        checkReset("reset");
        rst = 1'b0;
        #1;
        checkBit("req_first_cycle", imem_req, 1'b0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stream_addr", imem_addr, 32'(4 * i));
            checkBit("stream_req", imem_req, 1'b1);
            stepCycle();
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) stepCycle();
            checkBit("stream_valid", inst_valid, 1'b1);
            checkOutput("stream_pc", pc, 32'(4 * i));
        end

        $display("[TB] clk_en stall");
        applyStimulus(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            checkBit("stall_req", imem_req, 1'b0);
            stepCycle();
            checkOutput("stall_pc", pc, 32'h8);
            checkBit("stall_valid", inst_valid, 1'b1);
            checkOutput("stall_inst", inst, memWord(32'h8));
        end
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkBit("resume_req", imem_req, 1'b1);
        checkOutput("resume_addr", imem_addr, 32'h14);
        for (int j = 0; j < 4; j++) begin
            stepCycle();
            checkBit("resume_valid", inst_valid, 1'b1);
            checkOutput("resume_pc", pc, 32'(12 + 4 * j));
        end

        $display("[TB] redirect with two outstanding, latency 3");
        lat = 3;
        stepCycle();
        stepCycle();
        checkBit("full_req", imem_req, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0103);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkBit("redir_valid", inst_valid, 1'b0);
        checkOutput("redir_inst", inst, NOP);
        checkBit("drain_req_a", imem_req, 1'b0);
        stepCycle();
        checkBit("drain_req_b", imem_req, 1'b0);
        stepCycle();
        waitReq(10);
        checkOutput("redir_addr", imem_addr, 32'h0000_0100);
        waitValid(20);
        checkOutput("redir_pc", pc, 32'h0000_0100);

        $display("[TB] redirect with same-cycle grant and response");
        drainIdle(1);
        imem_gnt = 1'b1;
        #1;
        checkBit("s4_req_a", imem_req, 1'b1);
        stepCycle();
        checkBit("s4_req_b", imem_req, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0400);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkBit("s4_valid", inst_valid, 1'b0);
        checkBit("s4_drain_req", imem_req, 1'b0);
        stepCycle();
        waitReq(10);
        checkOutput("s4_addr", imem_addr, 32'h0000_0400);
        waitValid(20);
        checkOutput("s4_pc", pc, 32'h0000_0400);

        $display("[TB] second redirect while draining");
        drainIdle(3);
        imem_gnt = 1'b1;
        #1;
        checkBit("s5_req_a", imem_req, 1'b1);
        stepCycle();
        checkBit("s5_req_b", imem_req, 1'b1);
        stepCycle();
        checkBit("s5_req_full", imem_req, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0100);
        stepCycle();
        checkBit("s5_drain_req", imem_req, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'd0);
        waitReq(10);
        checkOutput("s5_addr", imem_addr, 32'h0000_0200);
        waitValid(20);
        checkOutput("s5_pc", pc, 32'h0000_0200);

        $display("[TB] address wrap and reset with a request outstanding");
        drainIdle(3);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'd0);
        imem_gnt = 1'b1;
        #1;
        checkBit("wrap_req_a", imem_req, 1'b1);
        checkOutput("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
        stepCycle();
        checkBit("wrap_req_b", imem_req, 1'b1);
        checkOutput("wrap_addr_b", imem_addr, 32'h0000_0000);
        rst = 1'b1;
        stepCycle();
        checkReset("midreset");
        rst = 1'b0;
        stepCycle();
        checkBit("restart_req", imem_req, 1'b1);
        checkOutput("restart_addr", imem_addr, 32'h0000_0000);
        waitValid(20);
        checkOutput("restart_pc", pc, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
